// File: rtl/la_capture_sequencer.sv
// la_capture_sequencer
//
// Sequencing controller for the logic analyzer edge capture path. After an
// arm request it waits for a masked trigger pattern on the four probe inputs,
// then records every probe edge together with a timestamp relative to the
// trigger into a small event buffer. When the buffer fills or the timestamp
// window runs out, the buffer is streamed out as bytes over valid/ready.
//
// Ports:
//   clk_i          single clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   in_data_i      probe inputs, already synchronized to clk_i
//   arm_i          one-cycle start request (honoured in IDLE and DONE)
//   abort_i        forces a return to IDLE and discards the buffer
//   trig_mask_i    trigger bit enables
//   trig_value_i   trigger pattern
//   rd_ready_i     consumer accepts the current byte
//   rd_valid_o     rd_data_o holds a valid byte
//   rd_data_o      readout byte: timestamp first, then {4'h0, data}
//   state_o        IDLE=00, ARMED=01, CAPTURE=10, DONE=11
//   count_o        number of buffer entries stored
//   window_end_o   capture ended because the timestamp reached its maximum

module la_capture_sequencer #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [3:0]             in_data_i,
  input  logic                   arm_i,
  input  logic                   abort_i,
  input  logic [3:0]             trig_mask_i,
  input  logic [3:0]             trig_value_i,
  input  logic                   rd_ready_i,
  output logic                   rd_valid_o,
  output logic [7:0]             rd_data_o,
  output logic [1:0]             state_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   window_end_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = AW + 2;
  localparam int EW = TS_W + 4;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [3:0]      prev_q, prev_d;
  logic [IW-1:0]   rdIdx_q, rdIdx_d;
  logic            windowEnd_q, windowEnd_d;
  logic [7:0]      rdData_q, rdData_d;
  logic [EW-1:0]   buf_q [DEPTH];

  logic            wrEn;
  logic [EW-1:0]   wrEntry;
  logic            trigHit;
  logic            rdValid;
  logic [EW-1:0]   rdEntry;

  // A masked-off bit never blocks the trigger, so a zero mask fires on the
  // very first ARMED cycle.
  assign trigHit = (((in_data_i ^ trig_value_i) & trig_mask_i) == 4'h0);

  // Each stored entry yields two bytes, so readout is live while the byte
  // index is below twice the entry count.
  assign rdValid = (state_q == DONE) && (rdIdx_q < {count_q, 1'b0});

  // Next-state logic for the sequencer. Abort is checked before anything
  // else so it wins over arm, trigger and readout in the same cycle. In
  // CAPTURE a filling write takes precedence over the timestamp window, which
  // keeps window_end low when both land on the same cycle. The readout byte
  // is registered, so it is preloaded from the index the DONE state will
  // have next cycle; this makes the first byte valid in the first DONE cycle
  // and keeps it steady while the consumer stalls.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ts_d        = ts_q;
    prev_d      = prev_q;
    rdIdx_d     = rdIdx_q;
    windowEnd_d = windowEnd_q;
    rdData_d    = rdData_q;
    wrEn        = 1'b0;
    wrEntry     = {ts_q, in_data_i};
    rdEntry     = '0;

    if (abort_i) begin
      state_d     = IDLE;
      count_d     = '0;
      rdIdx_d     = '0;
      windowEnd_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm_i) begin
            state_d     = ARMED;
            count_d     = '0;
            rdIdx_d     = '0;
            windowEnd_d = 1'b0;
          end else if (rdValid && rd_ready_i) begin
            rdIdx_d = rdIdx_q + IW'(1);
          end
        end
        ARMED: begin
          prev_d = in_data_i;
          if (trigHit) begin
            wrEn    = 1'b1;
            wrEntry = {{TS_W{1'b0}}, in_data_i};
            ts_d    = TS_W'(1);
            count_d = CW'(1);
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          ts_d   = ts_q + TS_W'(1);
          prev_d = in_data_i;
          if (in_data_i != prev_q) begin
            wrEn    = 1'b1;
            count_d = count_q + CW'(1);
          end
          if (wrEn && (count_d == FULL)) begin
            state_d = DONE;
          end else if (ts_q == '1) begin
            state_d     = DONE;
            windowEnd_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    rdEntry = buf_q[rdIdx_d[AW:1]];
    if ((state_d == DONE) && (rdIdx_d < {count_d, 1'b0})) begin
      rdData_d = rdIdx_d[0] ? {4'h0, rdEntry[3:0]} : rdEntry[EW-1:4];
    end
  end

  // Control registers. Reset returns everything to an idle, empty sequencer
  // with the read port quiet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      ts_q        <= '0;
      prev_q      <= '0;
      rdIdx_q     <= '0;
      windowEnd_q <= 1'b0;
      rdData_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ts_q        <= ts_d;
      prev_q      <= prev_d;
      rdIdx_q     <= rdIdx_d;
      windowEnd_q <= windowEnd_d;
      rdData_q    <= rdData_d;
    end
  end

  // Event buffer. Entries are appended at the current count, so they come
  // out in capture order. Contents need no reset because count gates reads.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wrEn) begin
      buf_q[count_q[AW-1:0]] <= wrEntry;
    end
  end

  assign rd_valid_o   = rdValid;
  assign rd_data_o    = rdData_q;
  assign state_o      = state_q;
  assign count_o      = count_q;
  assign window_end_o = windowEnd_q;

endmodule
